// File: rtl/a2b_dom_serial.sv
// Masked arithmetic-to-Boolean conversion: bit-serial ripple-carry addition of
// arithmetic shares into a Boolean-shared accumulator using DOM-indep AND gadgets.
// Optional macro A2B_CLEAR_ON_DONE_EN zeroes state after the output handshake.

module a2b_dom_and #(
  parameter int N = 2,
  parameter int L = 1
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  input  logic [L-1:0] r_i,
  output logic [N-1:0] z_o
);
  // One random bit per unordered share pair (a<b), shared by both cross terms.
  function automatic int pidx(input int a, input int b);
    int lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return lo * N - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  always_comb begin
    z_o = '0;
    for (int i = 0; i < N; i++) begin
      z_o[i] = x_i[i] & y_i[i];
      for (int j = 0; j < N; j++)
        if (j != i) z_o[i] = z_o[i] ^ ((x_i[i] & y_i[j]) ^ r_i[pidx(i, j)]);
    end
  end
endmodule

module a2b_dom_serial #(
  parameter int D = 1,
  parameter int N = D + 1,
  parameter int L = ((D + 1) * D) / 2,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*W-1:0]   port_a,
  input  logic [D*W-1:0]   port_r_ref,
  input  logic [2*L-1:0]   port_r_and,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*W-1:0]   port_c
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = $clog2(W);

  typedef enum logic [1:0] {IDLE, REFRESH, ADD, DONE} state_t;

  state_t                  state_q, state_d;
  logic [N-1:0][W-1:0]     s_q, s_d, b_q, b_d, ref_sh;
  logic [N-1:1][W-1:0]     a_q, a_d;
  logic [N-1:0]            c_q, c_d;
  logic [KW-1:0]           k_q, k_d;
  logic [IW-1:0]           i_q, i_d;
  logic [W-1:0]            src, rmask;
  logic [N-1:0]            s_lsb, b_lsb, sum, g1, g2;

  // Boolean refresh of one arithmetic share: A_0 on accept, else stored A_k.
  always_comb begin
    src = port_a[W-1:0];
    if (state_q != IDLE)
      for (int j = 1; j < N; j++)
        if (k_q == KW'(j)) src = a_q[j];
    rmask  = '0;
    ref_sh = '0;
    for (int j = 1; j <= D; j++) begin
      rmask     = rmask ^ port_r_ref[(j-1)*W +: W];
      ref_sh[j] = port_r_ref[(j-1)*W +: W];
    end
    ref_sh[0] = src ^ rmask;
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      s_lsb[j] = s_q[j][0];
      b_lsb[j] = b_q[j][0];
    end
    sum = s_lsb ^ b_lsb ^ c_q;
  end

  a2b_dom_and #(.N(N), .L(L)) u_gen (
    .x_i(s_lsb), .y_i(b_lsb), .r_i(port_r_and[L-1:0]), .z_o(g1)
  );
  a2b_dom_and #(.N(N), .L(L)) u_prop (
    .x_i(c_q), .y_i(s_lsb ^ b_lsb), .r_i(port_r_and[2*L-1:L]), .z_o(g2)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    a_d     = a_q;
    c_d     = c_q;
    k_d     = k_q;
    i_d     = i_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d = ref_sh;
          for (int j = 1; j < N; j++) a_d[j] = port_a[j*W +: W];
          k_d     = KW'(1);
          state_d = REFRESH;
        end
      end
      REFRESH: begin
        b_d     = ref_sh;
        c_d     = '0;
        i_d     = '0;
        state_d = ADD;
      end
      ADD: begin
        for (int j = 0; j < N; j++) begin
          s_d[j] = {sum[j], s_q[j][W-1:1]};
          b_d[j] = {1'b0, b_q[j][W-1:1]};
        end
        c_d = g1 ^ g2;
        i_d = i_q + IW'(1);
        if (i_q == IW'(W - 1)) begin
          if (k_q == KW'(N - 1)) state_d = DONE;
          else begin
            k_d     = k_q + KW'(1);
            state_d = REFRESH;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef A2B_CLEAR_ON_DONE_EN
          s_d = '0;
          b_d = '0;
          c_d = '0;
          a_d = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      a_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      a_q     <= a_d;
      c_q     <= c_d;
      k_q     <= k_d;
      i_q     <= i_d;
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE);
`ifdef A2B_CLEAR_ON_DONE_EN
  assign port_c = out_valid ? s_q : '0;
`else
  assign port_c = s_q;
`endif
endmodule

// File: tb/tb_a2b_dom_serial.sv
// Directed bench for a2b_dom_serial: D=1 and D=2 instances, latency, wrap,
// backpressure, mid-operation reset and post-handshake clearing.

module tb_a2b_dom_serial;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] pa, pc;
  logic [7:0]  rref;
  logic [1:0]  rnd_and;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [23:0] pa2, pc2;
  logic [15:0] rref2;
  logic [5:0]  rnd_and2;

  int checks = 0;
  int errors = 0;

  a2b_dom_serial #(.D(1), .W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .port_a(pa), .port_r_ref(rref), .port_r_and(rnd_and),
    .out_valid(out_valid), .out_ready(out_ready), .port_c(pc)
  );

  a2b_dom_serial #(.D(2), .W(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .port_a(pa2), .port_r_ref(rref2), .port_r_and(rnd_and2),
    .out_valid(out_valid2), .out_ready(out_ready2), .port_c(pc2)
  );

  task automatic run1(input logic [7:0] a0, input logic [7:0] a1, input bit rnd,
                      output logic [7:0] res, output int lat, output bit tmo);
    pa       = {a1, a0};
    rref     = rnd ? 8'($urandom) : 8'h00;
    rnd_and  = rnd ? 2'($urandom) : 2'b00;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pa       = 16'($urandom);
    lat = 0;
    tmo = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (rnd) begin
        rref    = 8'($urandom);
        rnd_and = 2'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin
        tmo = 1'b0;
        break;
      end
    end
    res = pc[7:0] ^ pc[15:8];
  endtask

  task automatic handshake1();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || pc !== 16'h0) begin
      errors++;
      $display("FAIL reset_d1: in_ready=%b out_valid=%b port_c=%h want 0 0 0000", in_ready, out_valid, pc);
    end
    checks++;
    if (in_ready2 !== 1'b0 || out_valid2 !== 1'b0 || pc2 !== 24'h0) begin
      errors++;
      $display("FAIL reset_d2: in_ready=%b out_valid=%b port_c=%h want 0 0 000000", in_ready2, out_valid2, pc2);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b in_ready2=%b want 1 1", in_ready, in_ready2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] res; int lat; bit tmo;
    run1(8'h37, 8'hD0, 1'b0, res, lat, tmo);
    checks++;
    if (tmo || lat != 9) begin
      errors++;
      $display("FAIL basic_latency: got %0d (timeout=%b) want 9", lat, tmo);
    end
    checks++;
    if (res !== 8'h07) begin
      errors++;
      $display("FAIL basic_result: got %h want 07", res);
    end
    handshake1();
  endtask

  task automatic test_wrap();
    logic [7:0] res, a0, a1; int lat; bit tmo;
    run1(8'hFF, 8'h01, 1'b1, res, lat, tmo);
    checks++;
    if (tmo || res !== 8'h00) begin
      errors++;
      $display("FAIL wrap_ff_01: got %h (timeout=%b) want 00", res, tmo);
    end
    handshake1();
    for (int v = 0; v < 1000; v++) begin
      a0 = 8'($urandom);
      a1 = 8'($urandom);
      run1(a0, a1, 1'b1, res, lat, tmo);
      checks++;
      if (tmo || lat != 9 || res !== 8'(a0 + a1)) begin
        errors++;
        $display("FAIL random_vec %0d: %h+%h got %h lat %0d want %h lat 9", v, a0, a1, res, lat, 8'(a0 + a1));
      end
      handshake1();
    end
  endtask

  task automatic test_d2();
    logic [7:0] res; int lat; bit tmo;
    pa2       = {8'h05, 8'h80, 8'h80};
    rref2     = 16'($urandom);
    rnd_and2  = 6'($urandom);
    in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    pa2 = 24'($urandom);
    lat = 0;
    tmo = 1'b1;
    for (int c = 0; c < 100; c++) begin
      rref2    = 16'($urandom);
      rnd_and2 = 6'($urandom);
      @(posedge clk); #1;
      lat++;
      if (out_valid2) begin
        tmo = 1'b0;
        break;
      end
    end
    res = pc2[7:0] ^ pc2[15:8] ^ pc2[23:16];
    checks++;
    if (tmo || lat != 18) begin
      errors++;
      $display("FAIL d2_latency: got %0d (timeout=%b) want 18", lat, tmo);
    end
    checks++;
    if (res !== 8'h05) begin
      errors++;
      $display("FAIL d2_result: got %h want 05", res);
    end
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    checks++;
    if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL d2_handshake: out_valid=%b in_ready=%b want 0 1", out_valid2, in_ready2);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] res; int lat; bit tmo;
    logic [15:0] held;
    run1(8'h12, 8'h34, 1'b1, res, lat, tmo);
    checks++;
    if (tmo || res !== 8'h46) begin
      errors++;
      $display("FAIL bp_result: got %h (timeout=%b) want 46", res, tmo);
    end
    held = pc;
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0] ? 1'b0 : 1'b1;
      pa       = 16'($urandom);
      rref     = 8'($urandom);
      rnd_and  = 2'($urandom);
      @(posedge clk); #1;
      checks++;
      if (pc !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold %0d: port_c=%h in_ready=%b out_valid=%b want %h 0 1", c, pc, in_ready, out_valid, held);
      end
    end
    in_valid = 1'b0;
    handshake1();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
`ifdef A2B_CLEAR_ON_DONE_EN
    checks++;
    if (pc !== 16'h0 || dut.s_q !== '0 || dut.b_q !== '0 || dut.c_q !== '0) begin
      errors++;
      $display("FAIL clear_after_done: port_c=%h s=%h b=%h c=%b want all zero", pc, dut.s_q, dut.b_q, dut.c_q);
    end
`else
    checks++;
    if (pc !== held) begin
      errors++;
      $display("FAIL keep_after_done: port_c=%h want %h", pc, held);
    end
`endif
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] res; int lat; bit tmo; bit seen;
    pa       = {8'h22, 8'h55};
    rref     = 8'($urandom);
    rnd_and  = 2'($urandom);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || pc !== 16'h0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b port_c=%h in_ready=%b want 0 0000 0", out_valid, pc, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_idle: got out_valid/in_ready disturbance=1 want 0");
    end
    run1(8'h10, 8'h20, 1'b1, res, lat, tmo);
    checks++;
    if (tmo || lat != 9 || res !== 8'h30) begin
      errors++;
      $display("FAIL reset_mid_recover: got %h lat %0d (timeout=%b) want 30 lat 9", res, lat, tmo);
    end
    handshake1();
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; pa = '0; rref = '0; rnd_and = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; pa2 = '0; rref2 = '0; rnd_and2 = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_d2();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
